// File: rtl/hdmi_video_timing_gen.sv
// Video timing generator: shadowed timing config, H/V counters, registered sync/DE outputs,
// and a pixel pacer that pulls from the upstream stream only during active video.
module hdmi_video_timing_gen #(
  parameter int CNT_WIDTH  = 12,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_enable,
  input  logic [CNT_WIDTH-1:0]  cfg_h_active,
  input  logic [CNT_WIDTH-1:0]  cfg_h_fp,
  input  logic [CNT_WIDTH-1:0]  cfg_h_sync,
  input  logic [CNT_WIDTH-1:0]  cfg_h_bp,
  input  logic [CNT_WIDTH-1:0]  cfg_v_active,
  input  logic [CNT_WIDTH-1:0]  cfg_v_fp,
  input  logic [CNT_WIDTH-1:0]  cfg_v_sync,
  input  logic [CNT_WIDTH-1:0]  cfg_v_bp,
  input  logic                  cfg_hsync_pol,
  input  logic                  cfg_vsync_pol,
  input  logic                  underflow_clr,
  input  logic [DATA_WIDTH-1:0] s_pix_tdata,
  input  logic                  s_pix_tvalid,
  output logic                  s_pix_tready,
  output logic [DATA_WIDTH-1:0] vid_data,
  output logic                  vid_de,
  output logic                  vid_hsync,
  output logic                  vid_vsync,
  output logic [CNT_WIDTH-1:0]  vid_x,
  output logic [CNT_WIDTH-1:0]  vid_y,
  output logic                  vid_sof,
  output logic                  cfg_err,
  output logic                  underflow
);

  localparam int SW = CNT_WIDTH + 2;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic                 en_prev;
  logic [CNT_WIDTH-1:0] sh_ha, sh_hfp, sh_hs, sh_hbp;
  logic [CNT_WIDTH-1:0] sh_va, sh_vfp, sh_vs, sh_vbp;
  logic                 sh_hpol, sh_vpol;
  logic [CNT_WIDTH-1:0] h_cnt, v_cnt;

  // Region boundaries are summed at full width so large configs cannot wrap.
  logic [SW-1:0] h_sync_start, h_sync_end, h_total;
  logic [SW-1:0] v_sync_start, v_sync_end, v_total;
  logic          h_act, v_act, h_syn, v_syn, h_last, v_last;
  logic          run, de_next, cfg_zero, load;

  always_comb begin
    h_sync_start = SW'(sh_ha) + SW'(sh_hfp);
    h_sync_end   = h_sync_start + SW'(sh_hs);
    h_total      = h_sync_end + SW'(sh_hbp);
    v_sync_start = SW'(sh_va) + SW'(sh_vfp);
    v_sync_end   = v_sync_start + SW'(sh_vs);
    v_total      = v_sync_end + SW'(sh_vbp);
    h_act  = SW'(h_cnt) < SW'(sh_ha);
    v_act  = SW'(v_cnt) < SW'(sh_va);
    h_syn  = (SW'(h_cnt) >= h_sync_start) && (SW'(h_cnt) < h_sync_end);
    v_syn  = (SW'(v_cnt) >= v_sync_start) && (SW'(v_cnt) < v_sync_end);
    h_last = SW'(h_cnt) == (h_total - SW'(1));
    v_last = SW'(v_cnt) == (v_total - SW'(1));
  end

  // Dropping enable stops the frame in the same cycle, so run is gated by the live input.
  assign run      = !ARESET && (state == RUN) && cfg_enable;
  assign de_next  = run && h_act && v_act;
  assign s_pix_tready = de_next;

  assign cfg_zero = (cfg_h_active == '0) || (cfg_h_fp == '0) || (cfg_h_sync == '0) ||
                    (cfg_h_bp == '0) || (cfg_v_active == '0) || (cfg_v_fp == '0) ||
                    (cfg_v_sync == '0) || (cfg_v_bp == '0);
  assign load     = cfg_enable && (!en_prev || ((state == RUN) && h_last && v_last));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sh_ha   <= '0;  sh_hfp <= '0;  sh_hs <= '0;  sh_hbp <= '0;
      sh_va   <= '0;  sh_vfp <= '0;  sh_vs <= '0;  sh_vbp <= '0;
      sh_hpol <= 1'b0;
      sh_vpol <= 1'b0;
    end else if (load) begin
      sh_ha   <= cfg_h_active;  sh_hfp <= cfg_h_fp;  sh_hs <= cfg_h_sync;  sh_hbp <= cfg_h_bp;
      sh_va   <= cfg_v_active;  sh_vfp <= cfg_v_fp;  sh_vs <= cfg_v_sync;  sh_vbp <= cfg_v_bp;
      sh_hpol <= cfg_hsync_pol;
      sh_vpol <= cfg_vsync_pol;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      en_prev <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      cfg_err <= 1'b0;
    end else begin
      en_prev <= cfg_enable;
      if (!cfg_enable) begin
        state <= IDLE;
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (load) begin
        // Both the enable edge and end-of-frame restart the counters on a fresh config.
        state   <= cfg_zero ? IDLE : RUN;
        cfg_err <= cfg_zero;
        h_cnt   <= '0;
        v_cnt   <= '0;
      end else if (state == RUN) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_cnt + CNT_WIDTH'(1);
        end else begin
          h_cnt <= h_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      vid_data  <= '0;
      vid_de    <= 1'b0;
      vid_hsync <= ~cfg_hsync_pol;
      vid_vsync <= ~cfg_vsync_pol;
      vid_x     <= '0;
      vid_y     <= '0;
      vid_sof   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      vid_data  <= (de_next && s_pix_tvalid) ? s_pix_tdata : '0;
      vid_de    <= de_next;
      vid_hsync <= run ? (h_syn ? sh_hpol : ~sh_hpol) : ~cfg_hsync_pol;
      vid_vsync <= run ? (v_syn ? sh_vpol : ~sh_vpol) : ~cfg_vsync_pol;
      vid_x     <= run ? h_cnt : '0;
      vid_y     <= run ? v_cnt : '0;
      vid_sof   <= run && (h_cnt == '0) && (v_cnt == '0);
      if (de_next && !s_pix_tvalid)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen: small 8x5 frame, underflow, live reconfig,
// zero-field config error, negative polarity, enable drop and mid-frame reset.
module tb_hdmi_video_timing_gen;
  localparam int CW = 12;
  localparam int DW = 24;

  logic          ACLK = 1'b0;
  logic          ARESET, cfg_enable;
  logic [CW-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CW-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic          cfg_hsync_pol, cfg_vsync_pol, underflow_clr;
  logic [DW-1:0] s_pix_tdata;
  logic          s_pix_tvalid, s_pix_tready;
  logic [DW-1:0] vid_data;
  logic          vid_de, vid_hsync, vid_vsync, vid_sof, cfg_err, underflow;
  logic [CW-1:0] vid_x, vid_y;

  hdmi_video_timing_gen #(.CNT_WIDTH(CW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_enable(cfg_enable),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol), .underflow_clr(underflow_clr),
    .s_pix_tdata(s_pix_tdata), .s_pix_tvalid(s_pix_tvalid), .s_pix_tready(s_pix_tready),
    .vid_data(vid_data), .vid_de(vid_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .vid_x(vid_x), .vid_y(vid_y), .vid_sof(vid_sof), .cfg_err(cfg_err), .underflow(underflow)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_mis = 0;
  int n_tready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [DW-1:0] pix(input int i);
    return 24'hA50000 + 24'(i);
  endfunction

  initial begin
    ARESET = 1'b1;  cfg_enable = 1'b0;  underflow_clr = 1'b0;
    cfg_h_active = 12'd4;  cfg_h_fp = 12'd1;  cfg_h_sync = 12'd2;  cfg_h_bp = 12'd1;
    cfg_v_active = 12'd2;  cfg_v_fp = 12'd1;  cfg_v_sync = 12'd1;  cfg_v_bp = 12'd1;
    cfg_hsync_pol = 1'b1;  cfg_vsync_pol = 1'b1;
    s_pix_tdata = '0;  s_pix_tvalid = 1'b1;
    tick;
    tick;
    check("rst_de",     32'(vid_de), 32'd0);
    check("rst_hsync",  32'(vid_hsync), 32'd0);
    check("rst_vsync",  32'(vid_vsync), 32'd0);
    check("rst_sof",    32'(vid_sof), 32'd0);
    check("rst_err",    32'(cfg_err), 32'd0);
    check("rst_uf",     32'(underflow), 32'd0);
    check("rst_tready", 32'(s_pix_tready), 32'd0);
    check("rst_data",   32'(vid_data), 32'd0);

    // Two 40-cycle frames; pixel (x=2,y=1) of frame 2 is missing.
    ARESET = 1'b0;  cfg_enable = 1'b1;
    tick;
    check("first_tready", 32'(s_pix_tready), 32'd1);
    check("first_de",     32'(vid_de), 32'd0);
    s_pix_tdata = pix(0);
    for (int i = 0; i < 80; i++) begin
      int p, x, y;
      logic de;
      p = i % 40;  x = p % 8;  y = p / 8;
      de = (x < 4) && (y < 2);
      check("a_tready", 32'(s_pix_tready), 32'(de));
      if (s_pix_tready) n_tready++;
      tick;
      check("a_de",    32'(vid_de), 32'(de));
      check("a_hsync", 32'(vid_hsync), 32'(x >= 5 && x <= 6));
      check("a_vsync", 32'(vid_vsync), 32'(y == 3));
      check("a_sof",   32'(vid_sof), 32'(p == 0));
      check("a_uf",    32'(underflow), 32'(i >= 50));
      if (de) begin
        check("a_x",    32'(vid_x), 32'(x));
        check("a_y",    32'(vid_y), 32'(y));
        check("a_data", 32'(vid_data), (i == 50) ? 32'd0 : 32'(pix(i)));
      end else begin
        check("a_data_blank", 32'(vid_data), 32'd0);
      end
      s_pix_tdata  = pix(i + 1);
      s_pix_tvalid = (i + 1 != 50);
    end
    check("tready_count", 32'(n_tready), 32'd16);
    underflow_clr = 1'b1;
    tick;
    underflow_clr = 1'b0;
    check("uf_cleared", 32'(underflow), 32'd0);

    // Mid-frame h_active change only takes effect from the next frame (H_TOTAL 8 -> 10).
    cfg_enable = 1'b0;
    tick;
    check("dis_de",     32'(vid_de), 32'd0);
    check("dis_hsync",  32'(vid_hsync), 32'd0);
    check("dis_tready", 32'(s_pix_tready), 32'd0);
    cfg_enable = 1'b1;
    tick;
    for (int j = 0; j < 100; j++) begin
      int x, y, k;
      logic de, hs;
      if (j == 20) cfg_h_active = 12'd6;
      if (j < 40) begin
        x = j % 8;  y = j / 8;
        de = (x < 4) && (y < 2);  hs = (x >= 5) && (x <= 6);
      end else begin
        k = (j - 40) % 50;  x = k % 10;  y = k / 10;
        de = (x < 6) && (y < 2);  hs = (x >= 7) && (x <= 8);
      end
      tick;
      check("b_de",    32'(vid_de), 32'(de));
      check("b_hsync", 32'(vid_hsync), 32'(hs));
      check("b_sof",   32'(vid_sof), 32'(j == 0 || j == 40 || j == 90));
    end

    // A zero field blocks the frame until enable is toggled with a fixed config.
    cfg_enable = 1'b0;  cfg_h_sync = 12'd0;  cfg_h_active = 12'd4;
    tick;
    cfg_enable = 1'b1;
    tick;
    check("err_set", 32'(cfg_err), 32'd1);
    for (int j = 0; j < 12; j++) begin
      check("err_tready", 32'(s_pix_tready), 32'd0);
      tick;
      check("err_de", 32'(vid_de), 32'd0);
    end
    cfg_h_sync = 12'd2;  cfg_enable = 1'b0;
    tick;
    check("err_hold", 32'(cfg_err), 32'd1);
    cfg_enable = 1'b1;
    tick;
    check("err_clr",     32'(cfg_err), 32'd0);
    check("err_tready1", 32'(s_pix_tready), 32'd1);
    tick;
    check("err_sof", 32'(vid_sof), 32'd1);
    check("err_de1", 32'(vid_de), 32'd1);

    // Active-low syncs, then enable dropped in the middle of line 1.
    cfg_enable = 1'b0;  cfg_hsync_pol = 1'b0;  cfg_vsync_pol = 1'b0;
    tick;
    check("neg_idle_h", 32'(vid_hsync), 32'd1);
    check("neg_idle_v", 32'(vid_vsync), 32'd1);
    cfg_enable = 1'b1;
    tick;
    for (int x = 0; x < 8; x++) begin
      tick;
      check("neg_hsync", 32'(vid_hsync), 32'(!(x >= 5 && x <= 6)));
      check("neg_vsync", 32'(vid_vsync), 32'd1);
      check("neg_de",    32'(vid_de), 32'(x < 4));
    end
    tick;
    check("neg_l1_de", 32'(vid_de), 32'd1);
    check("neg_l1_y",  32'(vid_y), 32'd1);
    cfg_enable = 1'b0;
    #1;
    check("drop_tready", 32'(s_pix_tready), 32'd0);
    tick;
    check("drop_de",    32'(vid_de), 32'd0);
    check("drop_hsync", 32'(vid_hsync), 32'd1);
    check("drop_vsync", 32'(vid_vsync), 32'd1);
    cfg_enable = 1'b1;
    tick;
    tick;
    check("reen_sof", 32'(vid_sof), 32'd1);
    check("reen_x",   32'(vid_x), 32'd0);
    check("reen_y",   32'(vid_y), 32'd0);

    // Underflow, then a one-cycle reset in the middle of the frame.
    s_pix_tvalid = 1'b0;
    tick;
    s_pix_tvalid = 1'b1;
    check("pre_rst_uf", 32'(underflow), 32'd1);
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    check("mrst_de",     32'(vid_de), 32'd0);
    check("mrst_sof",    32'(vid_sof), 32'd0);
    check("mrst_x",      32'(vid_x), 32'd0);
    check("mrst_y",      32'(vid_y), 32'd0);
    check("mrst_data",   32'(vid_data), 32'd0);
    check("mrst_hsync",  32'(vid_hsync), 32'd1);
    check("mrst_vsync",  32'(vid_vsync), 32'd1);
    check("mrst_err",    32'(cfg_err), 32'd0);
    check("mrst_uf",     32'(underflow), 32'd0);
    check("mrst_tready", 32'(s_pix_tready), 32'd0);
    tick;
    check("post_rst_de", 32'(vid_de), 32'd0);
    tick;
    check("post_rst_sof", 32'(vid_sof), 32'd1);
    check("post_rst_de1", 32'(vid_de), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
